// File: rtl/div_if.sv
// Start/busy/done handshake and operand/result bus for the sequential divider.
// DIV_ABORT_EN adds the abort request used on pipeline flush.
interface div_if #(parameter int WIDTH = 32);
  logic             start;
`ifdef DIV_ABORT_EN
  logic             abort;
`endif
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output start,
`ifdef DIV_ABORT_EN
    output abort,
`endif
    output is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start,
`ifdef DIV_ABORT_EN
    input  abort,
`endif
    input  is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// Restoring shift-subtract divider sequencer for MIPS DIV/DIVU, one quotient bit per cycle.
// Optional DIV_ABORT_EN: abort in CALC/FIX returns to IDLE without producing done.
module div_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic  clk,
  input  logic  rst_n,
  div_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] q, rem, dvs_abs, dvd_raw;
  logic             dvd_neg, dvs_neg;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem_shift, diff;
  logic             take, abort_req;

  logic             busy_r, done_r, dz_r;
  logic [WIDTH-1:0] quot_r, remd_r;

`ifdef DIV_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  // Dividend magnitude lives in q and is shifted out MSB-first as quotient bits shift in.
  assign rem_shift = {rem, q[WIDTH-1]};
  assign diff      = rem_shift + ~{1'b0, dvs_abs} + (WIDTH+1)'(1);
  assign take      = ~diff[WIDTH];

  function automatic logic [WIDTH-1:0] mag(input logic sgn, input logic [WIDTH-1:0] v);
    return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.quotient  = quot_r;
  assign bus.remainder = remd_r;
  assign bus.div_zero  = dz_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      q       <= '0;
      rem     <= '0;
      dvs_abs <= '0;
      dvd_raw <= '0;
      dvd_neg <= 1'b0;
      dvs_neg <= 1'b0;
      cnt     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dz_r    <= 1'b0;
      quot_r  <= '0;
      remd_r  <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            q       <= mag(bus.is_signed, bus.dividend);
            rem     <= '0;
            dvs_abs <= mag(bus.is_signed, bus.divisor);
            dvd_raw <= bus.dividend;
            dvd_neg <= bus.is_signed & bus.dividend[WIDTH-1];
            dvs_neg <= bus.is_signed & bus.divisor[WIDTH-1];
            cnt     <= '0;
            busy_r  <= 1'b1;
            state   <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (abort_req) begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end else begin
            rem <= take ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
            q   <= {q[WIDTH-2:0], take};
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH-1)) state <= FIX;
          end
        end
        FIX: begin
          if (abort_req) begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end else begin
            // Zero divisor: all-ones quotient falls out of the loop; remainder reports the raw dividend.
            if (dvs_abs == '0) begin
              quot_r <= '1;
              remd_r <= dvd_raw;
              dz_r   <= 1'b1;
            end else begin
              quot_r <= (dvd_neg ^ dvs_neg) ? (~q + WIDTH'(1)) : q;
              remd_r <= dvd_neg ? (~rem + WIDTH'(1)) : rem;
              dz_r   <= 1'b0;
            end
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Multi-cycle sequencer for integer division in the DCPU execute stage. It serves MIPS DIV and DIVU.
- It drives one shared subtract datapath with a restoring shift-subtract algorithm, one quotient bit per cycle.
- It presents a start/busy/done handshake to the pipeline hazard unit, which stalls while busy=1.
- Results feed the HI/LO write path: quotient→LO, remainder→HI.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, active-low, asynchronous; clears all state and outputs.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; captured with start.
- dividend  input  WIDTH  numerator; captured with start.
- divisor  input  WIDTH  denominator; captured with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; results are valid from this cycle on.
- quotient  output  WIDTH  registered quotient.
- remainder  output  WIDTH  registered remainder.
- div_zero  output  1  registered; divisor was 0 for the last completed operation.

Behaviour:
- Reset: state=IDLE; busy, done, div_zero=0; quotient, remainder=0; counter=0. Reset asserted mid-operation abandons it immediately; no done is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE → CALC when start=1 at the clock edge. This edge latches the operands, sign flags and the absolute values |dividend| and |divisor|. Absolute values are taken only when is_signed=1. counter←0.
- CALC, one iteration per cycle:
  - rem_shift = {rem[WIDTH-1:0], q[WIDTH-1]}, WIDTH+1 bits.
  - diff = rem_shift − {1'b0, |divisor|}, one WIDTH+1-bit subtraction (a + ~b + 1).
  - If diff is non-negative: rem←diff[WIDTH-1:0] and shift in quotient bit 1. Otherwise: rem←rem_shift and shift in 0.
  - After WIDTH iterations (counter==WIDTH-1) → FIX.
- FIX, one cycle:
  - If is_signed and the operand signs differ, negate the quotient.
  - If is_signed and the dividend is negative, negate the remainder (remainder sign follows the dividend).
  - Load the quotient/remainder output registers → DONE.
- DONE: done=1 for exactly this cycle. Then → IDLE, or → CALC if start=1 in the same cycle (back-to-back operations allowed).
- busy=1 in CALC and FIX, 0 in IDLE and DONE.
- Latency: start edge at cycle 0 → busy during cycles 1..WIDTH+1 → done in cycle WIDTH+2 (34 for WIDTH=32).
- start while busy: ignored; latched operands are unchanged.
- Outputs hold their last results until the next FIX. They do not change at start.
- Divide by zero:
  - Latency is unchanged and div_zero=1.
  - The FIX sign correction is skipped.
  - quotient = all ones; remainder = original dividend (raw, not absolute value).
  - div_zero is cleared at the next FIX with a nonzero divisor.
- Signed overflow, MIN / −1: quotient=0x80000000, remainder=0, div_zero=0. This is the natural result of the magnitude path; no special case is needed.
- Dividend 0: quotient=0, remainder=0.

Optional Feature:
- Macro: DIV_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit, placed after start).
  - abort=1 in CALC or FIX → IDLE at the next edge.
  - No done is produced; quotient, remainder and div_zero keep their previous values.
  - abort has priority over the CALC→FIX and FIX→DONE transitions. abort is ignored in IDLE and DONE.
  - Used on pipeline flush: exception or eret.
- Undefined: there is no abort port, and an operation always runs to DONE or reset.

Test Plan:
- Unsigned 100 / 7, is_signed=0 → done in cycle 34 after start; quotient=14, remainder=2, div_zero=0; busy high in cycles 1..33.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002) → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Repeat 7 / −2 → quotient=0xFFFFFFFD, remainder=1.
- 0x00001234 / 0, both is_signed values → quotient=0xFFFFFFFF, remainder=0x00001234, div_zero=1. A following 9 / 3 clears div_zero: quotient=3, remainder=0.
- Signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0. The same operands unsigned → quotient=0, remainder=0x80000000.
- Flow control:
  - start pulsed with new operands at cycle 10 of a busy operation → ignored; the original result is produced at cycle 34.
  - start asserted in the done cycle → second op accepted; its done arrives 34 cycles later.
  - rst_n low at cycle 20 → busy, done and the outputs go to 0 immediately, and no done pulse follows.
- With DIV_ABORT_EN: abort at cycle 15 of 100/7 → busy=0 at cycle 16; no done; outputs keep the previous result. A next start of 100/7 → quotient=14, remainder=2.
